// File: rtl/axis_serializer.sv
`default_nettype none
// ============================================================================
// Module   : axis_serializer
// Purpose  : Splits one wide AXI-stream word into BYTES narrow beats, LSB first.
// Revision : 1.0
// ============================================================================
module axis_serializer #(
  parameter int WIDTH      = 8,
  parameter int BYTES      = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BYTES*WIDTH-1:0] idata,
  input  logic                   ivalid,
  output logic                   iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   ovalid,
  output logic                   olast,
  input  logic                   oready,
  output logic [SIZE_WIDTH-1:0]  size
);

  logic [BYTES*WIDTH-1:0] shift_q, shift_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic                   olast_q, olast_d;
  logic                   w_in_fire;
  logic                   w_out_fire;

  assign ovalid     = (size_q != '0);
  // oready feeds iready so the next word can load on the cycle the last beat leaves
  assign iready     = (size_q == '0) || ((size_q == SIZE_WIDTH'(1)) && oready);
  assign w_in_fire  = ivalid && iready;
  assign w_out_fire = ovalid && oready;

  always_comb begin
    shift_d = shift_q;
    size_d  = size_q;
    olast_d = olast_q;
    if (w_in_fire) begin
      shift_d = idata;
      size_d  = SIZE_WIDTH'(BYTES);
      olast_d = 1'b0;
    end else if (w_out_fire) begin
      shift_d = shift_q >> WIDTH;
      size_d  = size_q - SIZE_WIDTH'(1);
      olast_d = (size_q == SIZE_WIDTH'(2));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      size_q  <= '0;
      olast_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      size_q  <= size_d;
      olast_q <= olast_d;
    end
  end

  assign odata = shift_q[WIDTH-1:0];
  assign olast = olast_q;
  assign size  = size_q;

endmodule
`default_nettype wire
